// File: rtl/trafparser_pkg.sv
// Shared definitions for the trafparser chain: TPID constants, VLAN decoder
// states, type/TCI slot positions within the first words and TPID matching.
package trafparser_pkg;

  localparam logic [15:0] TPID_8100 = 16'h8100;
  localparam logic [15:0] TPID_88A8 = 16'h88A8;
  localparam logic [15:0] TPID_9100 = 16'h9100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W1,
    S_W2,
    S_W3,
    S_BODY
  } vlan_state_t;

  // Slot positions: T0/TCI0 in word1, T1/TCI1/T2/TCI2 in word2, T3 in word3.
  localparam int unsigned T0_MSB   = 31;
  localparam int unsigned T0_LSB   = 16;
  localparam int unsigned TCI0_MSB = 15;
  localparam int unsigned TCI0_LSB = 0;
  localparam int unsigned T1_MSB   = 63;
  localparam int unsigned T1_LSB   = 48;
  localparam int unsigned TCI1_MSB = 47;
  localparam int unsigned TCI1_LSB = 32;
  localparam int unsigned T2_MSB   = 31;
  localparam int unsigned T2_LSB   = 16;
  localparam int unsigned TCI2_MSB = 15;
  localparam int unsigned TCI2_LSB = 0;
  localparam int unsigned T3_MSB   = 63;
  localparam int unsigned T3_LSB   = 48;

  typedef struct packed {
    logic [2:0]  vid_en;
    logic [15:0] tci0;
    logic [15:0] tci1;
    logic [15:0] tci2;
    logic [15:0] ethtype;
    logic        l25_en;
    logic        ovf;
  } vlan_meta_t;

  function automatic logic is_tpid(logic [15:0] tpe, bit accept_9100);
    return (tpe == TPID_8100) || (tpe == TPID_88A8) ||
           (accept_9100 && (tpe == TPID_9100));
  endfunction

endpackage

// File: rtl/vlan_parser.sv
// 802.1Q/802.1ad tag-stack decoder: strips up to three tags from the first
// packet words and re-emits the stream one cycle later with tag metadata.
module vlan_parser
  import trafparser_pkg::*;
#(
  parameter int ACCEPT_9100_P = 1,
  parameter int MAX_TAGS_P    = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        srst_i,
  input  logic [63:0] pkt_data_i,
  input  logic [2:0]  pkt_mod_i,
  input  logic        pkt_sop_i,
  input  logic        pkt_eop_i,
  input  logic        pkt_en_i,
  output logic [63:0] pkt_data_o,
  output logic [2:0]  pkt_mod_o,
  output logic        pkt_sop_o,
  output logic        pkt_eop_o,
  output logic        pkt_en_o,
  output logic        vlan0_vid_en_o,
  output logic        vlan1_vid_en_o,
  output logic        vlan2_vid_en_o,
  output logic [15:0] vlan0_o,
  output logic [15:0] vlan1_o,
  output logic [15:0] vlan2_o,
  output logic [15:0] ethtype_o,
  output logic        l25_en_o,
  output logic        vlan_ovf_o
);

  localparam bit ACC_9100 = (ACCEPT_9100_P != 0);
  localparam bit CAP_TAG1 = (MAX_TAGS_P >= 2);
  localparam bit CAP_TAG2 = (MAX_TAGS_P >= 3);

  vlan_state_t state_q, state_d;
  vlan_meta_t  meta_q, meta_d;

  logic [63:0] data_q, data_d;
  logic [2:0]  mod_q, mod_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        en_q, en_d;

  logic [15:0] slot_t0, slot_tci0, slot_t1, slot_tci1, slot_t2, slot_tci2, slot_t3;
  logic        t0_tpid, t1_tpid, t2_tpid, t3_tpid;

  assign slot_t0   = pkt_data_i[T0_MSB:T0_LSB];
  assign slot_tci0 = pkt_data_i[TCI0_MSB:TCI0_LSB];
  assign slot_t1   = pkt_data_i[T1_MSB:T1_LSB];
  assign slot_tci1 = pkt_data_i[TCI1_MSB:TCI1_LSB];
  assign slot_t2   = pkt_data_i[T2_MSB:T2_LSB];
  assign slot_tci2 = pkt_data_i[TCI2_MSB:TCI2_LSB];
  assign slot_t3   = pkt_data_i[T3_MSB:T3_LSB];

  assign t0_tpid = is_tpid(slot_t0, ACC_9100);
  assign t1_tpid = is_tpid(slot_t1, ACC_9100);
  assign t2_tpid = is_tpid(slot_t2, ACC_9100);
  assign t3_tpid = is_tpid(slot_t3, ACC_9100);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else if (srst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the FSM only advances on valid words
  always_comb begin
    state_d = state_q;
    if (pkt_en_i) begin
      if (pkt_sop_i) begin
        state_d = S_W1;
      end else begin
        unique case (state_q)
          S_IDLE: state_d = S_IDLE;
          S_W1:   state_d = t0_tpid ? S_W2 : S_BODY;
          S_W2:   state_d = (CAP_TAG2 && t1_tpid && t2_tpid) ? S_W3 : S_BODY;
          S_W3:   state_d = S_BODY;
          S_BODY: state_d = S_BODY;
          default: state_d = S_IDLE;
        endcase
      end
      if (pkt_eop_i) begin
        state_d = S_IDLE;
      end
    end
  end

  // Metadata decode; a TPID in the slot past the tag limit becomes the
  // final type with the overflow flag set.
  always_comb begin
    meta_d = meta_q;
    if (pkt_en_i) begin
      if (pkt_sop_i) begin
        meta_d = '0;
      end else begin
        unique case (state_q)
          S_IDLE: meta_d = '0;
          S_W1: begin
            if (t0_tpid) begin
              meta_d.vid_en[0] = 1'b1;
              meta_d.tci0      = slot_tci0;
            end else begin
              meta_d.ethtype = slot_t0;
              meta_d.l25_en  = 1'b1;
            end
          end
          S_W2: begin
            if (!t1_tpid || !CAP_TAG1) begin
              meta_d.ethtype = slot_t1;
              meta_d.ovf     = t1_tpid;
              meta_d.l25_en  = 1'b1;
            end else begin
              meta_d.vid_en[1] = 1'b1;
              meta_d.tci1      = slot_tci1;
              if (!t2_tpid || !CAP_TAG2) begin
                meta_d.ethtype = slot_t2;
                meta_d.ovf     = t2_tpid;
                meta_d.l25_en  = 1'b1;
              end else begin
                meta_d.vid_en[2] = 1'b1;
                meta_d.tci2      = slot_tci2;
              end
            end
          end
          S_W3: begin
            meta_d.ethtype = slot_t3;
            meta_d.ovf     = t3_tpid;
            meta_d.l25_en  = 1'b1;
          end
          S_BODY:  meta_d = meta_q;
          default: meta_d = meta_q;
        endcase
      end
    end
  end

  always_comb begin
    data_d = data_q;
    mod_d  = mod_q;
    sop_d  = sop_q;
    eop_d  = eop_q;
    en_d   = pkt_en_i;
    if (pkt_en_i) begin
      data_d = pkt_data_i;
      mod_d  = pkt_mod_i;
      sop_d  = pkt_sop_i;
      eop_d  = pkt_eop_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      data_q <= '0;
      mod_q  <= '0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      en_q   <= 1'b0;
    end else if (srst_i) begin
      meta_q <= '0;
      data_q <= '0;
      mod_q  <= '0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      meta_q <= meta_d;
      data_q <= data_d;
      mod_q  <= mod_d;
      sop_q  <= sop_d;
      eop_q  <= eop_d;
      en_q   <= en_d;
    end
  end

  assign pkt_data_o     = data_q;
  assign pkt_mod_o      = mod_q;
  assign pkt_sop_o      = sop_q;
  assign pkt_eop_o      = eop_q;
  assign pkt_en_o       = en_q;
  assign vlan0_vid_en_o = meta_q.vid_en[0];
  assign vlan1_vid_en_o = meta_q.vid_en[1];
  assign vlan2_vid_en_o = meta_q.vid_en[2];
  assign vlan0_o        = meta_q.tci0;
  assign vlan1_o        = meta_q.tci1;
  assign vlan2_o        = meta_q.tci2;
  assign ethtype_o      = meta_q.ethtype;
  assign l25_en_o       = meta_q.l25_en;
  assign vlan_ovf_o     = meta_q.ovf;

endmodule

// File: tb/tb_vlan_parser.sv
// Directed table-driven bench for vlan_parser with default parameters.
module tb_vlan_parser;

  logic        clk = 1'b0;
  logic        rst_n_i, srst_i;
  logic [63:0] pkt_data_i;
  logic [2:0]  pkt_mod_i;
  logic        pkt_sop_i, pkt_eop_i, pkt_en_i;
  logic [63:0] pkt_data_o;
  logic [2:0]  pkt_mod_o;
  logic        pkt_sop_o, pkt_eop_o, pkt_en_o;
  logic        vlan0_vid_en_o, vlan1_vid_en_o, vlan2_vid_en_o;
  logic [15:0] vlan0_o, vlan1_o, vlan2_o, ethtype_o;
  logic        l25_en_o, vlan_ovf_o;

  vlan_parser #(.ACCEPT_9100_P(1), .MAX_TAGS_P(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .srst_i(srst_i),
    .pkt_data_i(pkt_data_i), .pkt_mod_i(pkt_mod_i), .pkt_sop_i(pkt_sop_i),
    .pkt_eop_i(pkt_eop_i), .pkt_en_i(pkt_en_i),
    .pkt_data_o(pkt_data_o), .pkt_mod_o(pkt_mod_o), .pkt_sop_o(pkt_sop_o),
    .pkt_eop_o(pkt_eop_o), .pkt_en_o(pkt_en_o),
    .vlan0_vid_en_o(vlan0_vid_en_o), .vlan1_vid_en_o(vlan1_vid_en_o),
    .vlan2_vid_en_o(vlan2_vid_en_o),
    .vlan0_o(vlan0_o), .vlan1_o(vlan1_o), .vlan2_o(vlan2_o),
    .ethtype_o(ethtype_o), .l25_en_o(l25_en_o), .vlan_ovf_o(vlan_ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        srst, sop, eop, en;
    logic [63:0] data;
    logic [2:0]  mod;
    logic [2:0]  vid;
    logic [15:0] tci0, tci1, tci2, eth;
    logic        l25, ovf;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Expected stream outputs: the last valid input word, zeroed by reset
  logic [63:0] m_data;
  logic [2:0]  m_mod;
  logic        m_sop, m_eop, m_en;

  localparam logic [63:0] W0 = 64'h0011_2233_4455_6677;
  localparam logic [63:0] BD = 64'hDEAD_BEEF_0000_1111;
  localparam logic [63:0] JK = 64'hFFFF_0000_FFFF_0000;

  function automatic logic [63:0] w1(input logic [15:0] t0, input logic [15:0] c0);
    return {32'h0A0B_0C0D, t0, c0};
  endfunction
  function automatic logic [63:0] w2(input logic [15:0] t1, input logic [15:0] c1,
                                     input logic [15:0] t2, input logic [15:0] c2);
    return {t1, c1, t2, c2};
  endfunction
  function automatic logic [63:0] w3(input logic [15:0] t3);
    return {t3, 48'h4500_0054_0000};
  endfunction

  function automatic vec_t v(input logic sr, input logic sop, input logic eop, input logic en,
                             input logic [63:0] d, input logic [2:0] mod, input logic [2:0] vid,
                             input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                             input logic [15:0] eth, input logic l25, input logic ovf);
    vec_t r;
    r.srst = sr; r.sop = sop; r.eop = eop; r.en = en; r.data = d; r.mod = mod;
    r.vid = vid; r.tci0 = c0; r.tci1 = c1; r.tci2 = c2; r.eth = eth;
    r.l25 = l25; r.ovf = ovf;
    return r;
  endfunction

  task automatic check(input string name, input vec_t e);
    logic [68:0] act_m, exp_m;
    logic [69:0] act_s, exp_s;
    act_m = {vlan2_vid_en_o, vlan1_vid_en_o, vlan0_vid_en_o, vlan0_o, vlan1_o, vlan2_o,
             ethtype_o, l25_en_o, vlan_ovf_o};
    exp_m = {e.vid, e.tci0, e.tci1, e.tci2, e.eth, e.l25, e.ovf};
    checks++;
    if (act_m !== exp_m) begin
      errors++;
      $display("FAIL %s meta: got %h expected %h", name, act_m, exp_m);
    end
    act_s = {pkt_en_o, pkt_sop_o, pkt_eop_o, pkt_mod_o, pkt_data_o};
    exp_s = {m_en, m_sop, m_eop, m_mod, m_data};
    checks++;
    if (act_s !== exp_s) begin
      errors++;
      $display("FAIL %s stream: got %h expected %h", name, act_s, exp_s);
    end
  endtask

  task automatic model_clear();
    m_data = '0; m_mod = '0; m_sop = 1'b0; m_eop = 1'b0; m_en = 1'b0;
  endtask

  // Called at a falling edge: drive, wait one cycle, check at the next falling edge
  task automatic run_vec(input string name, input vec_t e);
    srst_i = e.srst; pkt_sop_i = e.sop; pkt_eop_i = e.eop; pkt_en_i = e.en;
    pkt_data_i = e.data; pkt_mod_i = e.mod;
    @(negedge clk);
    if (e.srst) model_clear();
    else begin
      m_en = e.en;
      if (e.en) begin
        m_data = e.data; m_mod = e.mod; m_sop = e.sop; m_eop = e.eop;
      end
    end
    check(name, e);
  endtask

  initial begin
    vec_t z;
    z = v(0, 0, 0, 0, '0, '0, '0, '0, '0, '0, '0, 0, 0);
    rst_n_i = 1'b0; srst_i = 1'b0; pkt_data_i = '0; pkt_mod_i = '0;
    pkt_sop_i = 1'b0; pkt_eop_i = 1'b0; pkt_en_i = 1'b0;
    model_clear();

    // untagged IPv4
    vecs.push_back(v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h0800, 16'h4500), 0, 3'b000, 0, 0, 0, 16'h0800, 1, 0));
    vecs.push_back(v(0,0,1,1, BD, 6, 3'b000, 0, 0, 0, 16'h0800, 1, 0));
    vecs.push_back(v(0,0,0,0, JK, 0, 3'b000, 0, 0, 0, 16'h0800, 1, 0));
    // one tag, with a 3-cycle stall between word1 and word2
    vecs.push_back(v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h8100, 16'h2064), 0, 3'b001, 16'h2064, 0, 0, 0, 0, 0));
    for (int unsigned i = 0; i < 3; i++)
      vecs.push_back(v(0,0,0,0, JK, 7, 3'b001, 16'h2064, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w2(16'h8847, 16'h0001, 16'h2140, 16'h0000), 0,
                     3'b001, 16'h2064, 0, 0, 16'h8847, 1, 0));
    vecs.push_back(v(0,0,1,1, BD, 0, 3'b001, 16'h2064, 0, 0, 16'h8847, 1, 0));
    // three tags then IPv4
    vecs.push_back(v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h88A8, 16'h0064), 0, 3'b001, 16'h0064, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w2(16'h8100, 16'h00C8, 16'h8100, 16'h012C), 0,
                     3'b111, 16'h0064, 16'h00C8, 16'h012C, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w3(16'h0800), 0, 3'b111, 16'h0064, 16'h00C8, 16'h012C, 16'h0800, 1, 0));
    vecs.push_back(v(0,0,1,1, BD, 2, 3'b111, 16'h0064, 16'h00C8, 16'h012C, 16'h0800, 1, 0));
    // four TPIDs (0x9100 included): overflow
    vecs.push_back(v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h8100, 16'h0001), 0, 3'b001, 16'h0001, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w2(16'h8100, 16'h0002, 16'h9100, 16'h0003), 0,
                     3'b111, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w3(16'h8100), 0, 3'b111, 16'h0001, 16'h0002, 16'h0003, 16'h8100, 1, 1));
    vecs.push_back(v(0,0,1,1, BD, 0, 3'b111, 16'h0001, 16'h0002, 16'h0003, 16'h8100, 1, 1));
    // two tags, final type in T2
    vecs.push_back(v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h8100, 16'h0AAA), 0, 3'b001, 16'h0AAA, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w2(16'h88A8, 16'h0BBB, 16'h86DD, 16'h6000), 0,
                     3'b011, 16'h0AAA, 16'h0BBB, 0, 16'h86DD, 1, 0));
    vecs.push_back(v(0,0,1,1, BD, 3, 3'b011, 16'h0AAA, 16'h0BBB, 0, 16'h86DD, 1, 0));
    // short packet, idle hold, stray word in idle
    vecs.push_back(v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,1,1, w1(16'h8100, 16'h0123), 4, 3'b001, 16'h0123, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,0, JK, 0, 3'b001, 16'h0123, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h0800, 16'h4500), 0, 3'b000, 0, 0, 0, 0, 0, 0));
    // one-word packet, then a stray word must see the FSM idle
    vecs.push_back(v(0,1,1,1, W0, 5, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h0800, 16'h4500), 0, 3'b000, 0, 0, 0, 0, 0, 0));
    // new sop at word2 restarts decoding
    vecs.push_back(v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h8100, 16'h2064), 0, 3'b001, 16'h2064, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,1,0,1, w2(16'h8847, 16'h0001, 16'h2140, 16'h0000), 0, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h0800, 16'h4500), 0, 3'b000, 0, 0, 0, 16'h0800, 1, 0));
    vecs.push_back(v(0,0,1,1, BD, 0, 3'b000, 0, 0, 0, 16'h0800, 1, 0));
    // synchronous reset mid-packet
    vecs.push_back(v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h8100, 16'h0777), 0, 3'b001, 16'h0777, 0, 0, 0, 0, 0));
    vecs.push_back(v(1,0,0,1, w2(16'h0800, 16'h1111, 16'h2222, 16'h3333), 1, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w2(16'h0800, 16'h1111, 16'h2222, 16'h3333), 1, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0,0,0,1, w1(16'h86DD, 16'h6000), 0, 3'b000, 0, 0, 0, 16'h86DD, 1, 0));
    vecs.push_back(v(0,0,0,1, BD, 0, 3'b000, 0, 0, 0, 16'h86DD, 1, 0));
    vecs.push_back(v(0,0,1,1, JK, 1, 3'b000, 0, 0, 0, 16'h86DD, 1, 0));

    repeat (3) @(negedge clk);
    check("reset_state", z);
    rst_n_i = 1'b1;

    for (int unsigned i = 0; i < vecs.size(); i++)
      run_vec($sformatf("vec%0d", i), vecs[i]);

    // Asynchronous reset during word2
    run_vec("ar_sop", v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    run_vec("ar_w1", v(0,0,0,1, w1(16'h8100, 16'h2064), 0, 3'b001, 16'h2064, 0, 0, 0, 0, 0));
    pkt_sop_i = 1'b0; pkt_eop_i = 1'b0; pkt_en_i = 1'b1;
    pkt_data_i = w2(16'h8847, 16'h0001, 16'h2140, 16'h0000);
    #2 rst_n_i = 1'b0;
    #1;
    model_clear();
    check("ar_async_clear", z);
    @(negedge clk);
    check("ar_held", z);
    rst_n_i = 1'b1;
    run_vec("ar_stray", v(0,0,0,1, w1(16'h0800, 16'h4500), 0, 3'b000, 0, 0, 0, 0, 0, 0));
    run_vec("ar_sop2", v(0,1,0,1, W0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    run_vec("ar_w1b", v(0,0,0,1, w1(16'h88A8, 16'h0005), 0, 3'b001, 16'h0005, 0, 0, 0, 0, 0));
    run_vec("ar_w2b", v(0,0,1,1, w2(16'h0800, 16'h4500, 16'h0054, 16'h0000), 0,
                        3'b001, 16'h0005, 0, 0, 16'h0800, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vlan_parser.md
# vlan_parser

Layer-2 tag decoder in the trafparser chain, directly upstream of the MPLS parser. It walks the first four 64-bit words of each packet, strips up to three 802.1Q/802.1ad tags, and extracts the final ethertype. It then re-emits the word stream one cycle later with per-word metadata: tag enables, TCIs, ethertype and a layer-2.5 word strobe.

## Interface
Parameters:
- `ACCEPT_9100_P`, default 1: treat 0x9100 as a TPID in addition to 0x8100 and 0x88A8.
- `MAX_TAGS_P`, default 3: tag-stack depth; values 1..3 only.

Ports:
- `clk_i`  in  1  single clock; everything is sampled on its rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `srst_i`  in  1  synchronous reset, active-high; same effect as `rst_n_i`.
- `pkt_data_i`  in  64  packet word; byte 0 is `[63:56]`.
- `pkt_mod_i`  in  3  valid bytes in an eop word (0 = 8).
- `pkt_sop_i`, `pkt_eop_i`, `pkt_en_i`  in  1  start, end, word-valid.
- `pkt_data_o`, `pkt_mod_o`, `pkt_sop_o`, `pkt_eop_o`, `pkt_en_o`  out  64/3/1/1/1  input stream delayed by 1 cycle.
- `vlan0_vid_en_o`, `vlan1_vid_en_o`, `vlan2_vid_en_o`  out  1  tag N present.
- `vlan0_o`, `vlan1_o`, `vlan2_o`  out  16  TCI of tag N.
- `ethtype_o`  out  16  final ethertype.
- `l25_en_o`  out  1  current output word is at or after the final ethertype.
- `vlan_ovf_o`  out  1  a TPID was found after `MAX_TAGS_P` tags.

## Operation
- Type/TCI byte locations:
  - Byte offsets: T0 = bytes 12-13, tag 0 TCI = 14-15, T1 = 16-17, tag 1 TCI = 18-19, T2 = 20-21, tag 2 TCI = 22-23, T3 = 24-25.
  - Word positions: T0 = word1`[31:16]`, TCI0 = word1`[15:0]`, T1 = word2`[63:48]`, TCI1 = word2`[47:32]`, T2 = word2`[31:16]`, TCI2 = word2`[15:0]`, T3 = word3`[63:48]`.
- FSM states: S_IDLE, S_W1, S_W2, S_W3, S_BODY. Transitions happen only on words with `pkt_en_i`=1.
  - `pkt_sop_i` in any state: clear all metadata, go to S_W1. The sop word itself carries no type field.
  - S_W1:
    - T0 is a TPID: set vlan0 and capture TCI0, go to S_W2.
    - Otherwise: `ethtype_o` ← T0, set `l25_en` for this word, go to S_BODY.
  - S_W2:
    - T1 is not a TPID: final type is T1.
    - T1 is a TPID: capture tag 1. If T2 is also a TPID, capture tag 2 and go to S_W3; otherwise the final type is T2.
    - When a final type is found: `l25_en` is set for this word, go to S_BODY.
  - S_W3: final type is T3, go to S_BODY.
  - S_BODY: `l25_en` stays 1 until eop.
  - Any state with `pkt_eop_i`: go to S_IDLE after the word.
- Tag limit:
  - A TPID at the slot after `MAX_TAGS_P` tags is reported as `ethtype_o` = that TPID, with `vlan_ovf_o`=1.
  - With `MAX_TAGS_P` < 3, TPIDs beyond the limit are not captured.
- Short packet: eop before the final type is reached leaves `l25_en_o`=0 and `ethtype_o`=0 for the whole packet. Tags already seen are still reported.
- Words arriving in S_IDLE without sop are passed through with all metadata 0.

## Timing
- Latency is 1 cycle. Every output is registered and aligned with the corresponding `pkt_en_o` word.
- Metadata (`vlan*`, `ethtype_o`, `l25_en_o`, `vlan_ovf_o`):
  - Updates on the output word where the decode occurs.
  - Holds through the remainder of the packet, including the eop word and idle cycles.
  - Clears to 0 on the output of the next sop word.
- `pkt_en_i`=0 stalls the FSM. `pkt_en_o`=0 the next cycle; the other outputs hold.
- Reset (`rst_n_i` low or `srst_i`): every output becomes 0 and the FSM goes to S_IDLE.
  - A reset mid-packet discards the packet's remaining metadata.
  - Words after reset release are treated as in S_IDLE until the next sop.
- sop and eop in the same word (one-word packet): metadata is all 0 and the FSM ends in S_IDLE.

## Structure
- `trafparser_pkg` holds:
  - the TPID constants `TPID_8100`, `TPID_88A8`, `TPID_9100`;
  - the state enum `vlan_state_t`;
  - the type/TCI slot bit-range constants, shared with the MPLS parser's position macros.
- There are no sub-modules. TPID matching is a package function `is_tpid(logic [15:0], bit accept_9100)`.

## Test plan
- Untagged IPv4: T0 = 0x0800 → on output word1, `ethtype_o`=0x0800 and `l25_en_o`=1; all vid_en = 0.
- One tag: 0x8100 with TCI 0x2064, then 0x8847 → vlan0_vid_en=1, `vlan0_o`=0x2064; `l25_en_o` rises on word2 with `ethtype_o`=0x8847.
- Three tags (0x88A8, 0x8100, 0x8100), then 0x0800 → all three vid_en=1; `l25_en_o` first asserts on word3 with `ethtype_o`=0x0800.
- Four TPIDs → three tags captured, `ethtype_o`=0x8100, `vlan_ovf_o`=1.
- Stall and restart:
  - `pkt_en_i` low for 3 cycles between word1 and word2 → identical metadata to the no-stall run.
  - A new sop at word2 → the previous metadata clears and decoding restarts.
- `rst_n_i` asserted during word2 → all outputs 0 on the same edge; the next packet after release decodes correctly.
